// File: rtl/aes_enc_scheduler_pkg.sv
// Shared types and widths for the AES encrypter scheduler.
package aes_sched_pkg;
  localparam int AES_BLK_W = 128;

  typedef enum logic [2:0] {
    IDLE, KEYLOAD, ISSUE, WAIT, POP, CAPTURE, RESP
  } sched_state_t;
endpackage

// File: rtl/aes_enc_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or above ptr, with wrap.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);
  localparam int unsigned NU = N;

  // Walk from lowest to highest priority so the last hit is the winner.
  always_comb begin
    int unsigned idx;
    gnt     = '0;
    gnt_idx = '0;
    for (int unsigned k = 0; k < NU; k++) begin
      idx = (32'(ptr) + NU - 1 - k) % NU;
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
        gnt_idx  = IW'(idx);
      end
    end
  end
endmodule

// File: rtl/aes_enc_scheduler.sv
// Shares one aes_encrypter among N_REQ requesters, one block in flight,
// reloading the key schedule only when the granted key differs.
module aes_enc_scheduler
  import aes_sched_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int KEY_WAIT = 12,
  parameter int TIMEOUT  = 64,
  parameter int RD_LAT   = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*AES_BLK_W-1:0] req_key,
  input  logic [N_REQ*AES_BLK_W-1:0] req_data,
  output logic [N_REQ-1:0]           resp_valid,
  input  logic [N_REQ-1:0]           resp_ready,
  output logic [AES_BLK_W-1:0]       resp_data,
  output logic                       resp_err,
  output logic [AES_BLK_W-1:0]       enc_key,
  output logic                       enc_valid_key,
  output logic [AES_BLK_W-1:0]       enc_data,
  output logic                       enc_valid_in,
  output logic                       enc_rd_en_t,
  input  logic [AES_BLK_W-1:0]       enc_data_out,
  input  logic                       enc_valid_out,
  output logic                       busy
);
  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  sched_state_t         state;
  logic [IW-1:0]        rr_ptr, id, gnt_idx;
  logic [N_REQ-1:0]     gnt;
  logic [AES_BLK_W-1:0] cur_key, blk_key, blk_data, gnt_key, gnt_data;
  logic                 key_vld;
  logic [CW-1:0]        cnt;

  rr_arbiter #(.N(N_REQ), .IW(IW)) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign gnt_key  = req_key[gnt_idx*AES_BLK_W +: AES_BLK_W];
  assign gnt_data = req_data[gnt_idx*AES_BLK_W +: AES_BLK_W];

  // One counter serves as key-wait, timeout and read-latency timer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      id        <= '0;
      key_vld   <= 1'b0;
      cur_key   <= '0;
      blk_key   <= '0;
      blk_data  <= '0;
      cnt       <= '0;
      resp_data <= '0;
      resp_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (|req_valid) begin
          id       <= gnt_idx;
          blk_key  <= gnt_key;
          blk_data <= gnt_data;
          rr_ptr   <= (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
          cnt      <= '0;
          state    <= (key_vld && gnt_key == cur_key) ? ISSUE : KEYLOAD;
        end
        KEYLOAD: if (cnt == CW'(KEY_WAIT - 1)) begin
          cur_key <= blk_key;
          key_vld <= 1'b1;
          state   <= ISSUE;
        end else begin
          cnt <= cnt + 1'b1;
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: if (enc_valid_out) begin
          state <= POP;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          key_vld   <= 1'b0;
          resp_err  <= 1'b1;
          resp_data <= '0;
          state     <= RESP;
        end else begin
          cnt <= cnt + 1'b1;
        end
        POP: begin
          cnt   <= '0;
          state <= CAPTURE;
        end
        CAPTURE: if (cnt == CW'(RD_LAT - 1)) begin
          resp_data <= enc_data_out;
          resp_err  <= 1'b0;
          state     <= RESP;
        end else begin
          cnt <= cnt + 1'b1;
        end
        RESP: if (resp_ready[id]) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    resp_valid = '0;
    if (state == RESP) resp_valid[id] = 1'b1;
  end

  assign req_ready     = (state == IDLE && !rst) ? gnt : '0;
  assign enc_valid_key = (state == KEYLOAD);
  assign enc_key       = (state == KEYLOAD) ? blk_key : cur_key;
  assign enc_data      = blk_data;
  assign enc_valid_in  = (state == ISSUE);
  assign enc_rd_en_t   = (state == POP);
  assign busy          = (state != IDLE);
endmodule

// File: doc/aes_enc_scheduler.md
# aes_enc_scheduler

Controller that shares one `aes_encrypter` instance among `N_REQ` requesters, one block in flight at a time. It arbitrates round-robin among requesters and reloads the round-key schedule only when the granted key differs from the loaded one. It issues the block, waits for the encrypter's completion pulse, pops the encrypter output FIFO and returns the ciphertext to the owning requester. It sits directly above `aes_encrypter` and drives all of its control inputs.

## Interface
Parameters:
- `N_REQ`, 4, number of requesters (2..8)
- `KEY_WAIT`, 12, cycles `enc_valid_key` is held before the first data issue after a key load
- `TIMEOUT`, 64, max cycles in WAIT before the block is abandoned
- `RD_LAT`, 1, cycles from `enc_rd_en_t` to valid `enc_data_out`

Ports:
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `req_valid` in N_REQ: per-requester request
- `req_ready` out N_REQ: one-hot accept strobe
- `req_key` in N_REQ*128: key of requester i at [i*128 +: 128]
- `req_data` in N_REQ*128: plaintext of requester i, same packing
- `resp_valid` out N_REQ: one-hot response valid
- `resp_ready` in N_REQ: per-requester response accept
- `resp_data` out 128: ciphertext, shared
- `resp_err` out 1: response is a timeout error
- `enc_key` out 128: to encrypter `key`
- `enc_valid_key` out 1: to encrypter `valid_key`
- `enc_data` out 128: to encrypter `data_in`
- `enc_valid_in` out 1: to encrypter `valid_in`
- `enc_rd_en_t` out 1: to encrypter `fifo_rd_en_t`
- `enc_data_out` in 128: from encrypter `data_out`
- `enc_valid_out` in 1: from encrypter `valid_out`
- `busy` out 1: FSM not in IDLE

## Operation
- Reset: all outputs 0; FSM=IDLE; `rr_ptr`=0; `key_vld`=0; `cur_key`=0; counters 0. Reset mid-operation aborts the in-flight block silently. Any late `enc_valid_out` after reset is ignored because the FSM is in IDLE.
- Arbitration in IDLE:
  - Grant goes to the first `req_valid[i]` searching from `rr_ptr` upward, with wrap.
  - `req_ready[g]`=1 combinationally for that cycle only.
  - At the edge, the scheduler latches `id=g`, `blk_key`, `blk_data`, and sets `rr_ptr=(g+1)%N_REQ`.
- Key hit (`key_vld && blk_key==cur_key`): go to ISSUE. Otherwise go to KEYLOAD.
- KEYLOAD:
  - `enc_key=blk_key` and `enc_valid_key`=1 for exactly `KEY_WAIT` cycles.
  - Then `cur_key<=blk_key`, `key_vld<=1`, go to ISSUE.
- ISSUE: `enc_data=blk_data`, `enc_valid_in`=1 for one cycle, clear timer, go to WAIT.
- WAIT:
  - `enc_valid_out`=1 goes to POP.
  - If the timer reaches `TIMEOUT-1` first: `key_vld<=0`, `resp_err<=1`, `resp_data<=0`, go to RESP.
- POP: `enc_rd_en_t`=1 for one cycle, go to CAPTURE.
- CAPTURE: wait `RD_LAT` cycles, latch `resp_data<=enc_data_out`, `resp_err<=0`, go to RESP.
- RESP:
  - `resp_valid[id]`=1; `resp_data` and `resp_err` are held stable.
  - When `resp_ready[id]`=1, drop `resp_valid` and go to IDLE.
  - `resp_ready` of other requesters is ignored.
- `enc_key` holds `cur_key` outside KEYLOAD. `enc_data` holds `blk_data`.
- `req_valid` deasserted after acceptance has no effect. A requester may re-request in the same cycle its response completes; it is arbitrated in the next IDLE cycle.

## Timing
- `req_ready` is asserted only in IDLE. IDLE lasts one cycle whenever any `req_valid` is pending.
- Key-hit latency, accept edge T:
  - `enc_valid_in` high in cycle T+1.
  - POP in cycle E+1, where E is the first cycle with `enc_valid_out`=1.
  - `resp_valid` high from cycle E+2+`RD_LAT`.
- Key-miss adds exactly `KEY_WAIT` cycles before ISSUE.
- Timeout: `resp_valid` rises `TIMEOUT`+1 cycles after ISSUE.
- Back-to-back same requester, same key: no KEYLOAD between blocks.
- If `enc_valid_out` and timer expiry coincide, `enc_valid_out` wins and the block goes to POP.

## Structure
- Package `aes_sched_pkg`:
  - `typedef enum logic [2:0] {IDLE, KEYLOAD, ISSUE, WAIT, POP, CAPTURE, RESP} sched_state_t`
  - `AES_BLK_W=128`
- Sub-module `rr_arbiter` (param `N`): inputs `req` and `ptr`, outputs one-hot `gnt` and `gnt_idx`. Purely combinational.
- Timer and `RD_LAT` counter are local to the top module, with width `$clog2(TIMEOUT+1)`.

## Test plan
- Reset, then req0 with key `000102..0f` and data `00112233..eeff` → one KEYLOAD of 12 cycles, `enc_valid_in` single pulse, `resp_valid[0]` with `resp_data` equal to the encrypter model output `69c4e0d8..c55a`, `resp_err`=0.
- req0 issues a second block with the same key → no `enc_valid_key` assertion; `enc_valid_in` in the cycle after accept.
- req0..req3 all valid with the same key, `rr_ptr`=0 → grants in order 0,1,2,3. Then with req1 and req3 valid and `rr_ptr`=0 → grant 1, then 3.
- req2 with key A, then req2 with key B → second block performs KEYLOAD with `enc_key`=B for 12 cycles.
- Encrypter model never asserts `valid_out` → `resp_valid[id]` with `resp_err`=1 and `resp_data`=0 at ISSUE+65 cycles. The next request with the same key performs KEYLOAD.
- Hold `resp_ready`=0 for 10 cycles in RESP → `resp_data` stable, `req_ready` stays 0. Assert `rst` during WAIT → all outputs 0 within the same cycle, no response issued.
